// File: rtl/serial_add_unit.sv
// rtl/serial_add_unit.sv - bit-serial adder, LSB first, one full-adder slice built from two half adders
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN (adds the sub input port).

module halfadder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_add_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s0;
  logic             w_c0;
  logic             w_sbit;
  logic             w_c1;
  logic             w_cnext;
  logic             w_last;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as a + ~b + 1; cout then reads as NOT borrow.
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  halfadder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_s(w_s0),   .o_c(w_c0));
  halfadder u_ha1 (.i_a(w_s0),   .i_b(r_c),    .o_s(w_sbit), .o_c(w_c1));
  assign w_cnext = w_c0 | w_c1;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= w_b_load;
            r_c   <= w_c_load;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_sum <= {w_sbit, r_sum[WIDTH-1:1]};
          r_c   <= w_cnext;
          r_cnt <= r_cnt + 1'b1;
          // On the MSB slice r_c is the carry into bit WIDTH-1.
          if (w_last) begin
            r_cout <= w_cnext;
            r_ovf  <= r_c ^ w_cnext;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_serial_add_unit.sv
// tb/tb_serial_add_unit.sv - table-driven check of serial_add_unit at WIDTH=8 plus multi-cycle corner sequences

module tb_serial_add_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout),
    .overflow(overflow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive a start pulse; returns at the negedge following the sampling edge (edge 1).
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                        input logic tsub);
    a = ta;
    b = tb_;
    cin = tcin;
`ifdef SERIAL_ADD_SUB_EN
    sub = tsub;
`else
    if (tsub) $display("note: subtract vector requested without subtract build");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n is the edge count already elapsed; counts on until done or budget exhausted.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h3C, 8'h44, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0});
`endif

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'h00);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      a = ~vecs[i].a; b = ~vecs[i].b; cin = ~vecs[i].cin;
      wait_done(1, n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'd9);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_sum_hold", i), 32'(sum), 32'(vecs[i].exp_sum));
    end

    // Start while busy is ignored; then back-to-back start from the DONE cycle.
    launch(8'h01, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, n);
    chk("ignore_latency", 32'(n), 32'd9);
    chk("ignore_sum", 32'(sum), 32'h02);
    launch(8'h03, 8'h04, 1'b0, 1'b0);
    wait_done(1, n);
    chk("b2b_latency", 32'(n), 32'd9);
    chk("b2b_sum", 32'(sum), 32'h07);
    @(negedge clk);

    // Reset mid-operation aborts with no done pulse.
    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    chk("abort_sum", 32'(sum), 32'h00);

    // Reset and start together: reset wins.
    a = 8'h01; b = 8'h01; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
